// File: rtl/dmem_lsu.sv
// dmem_lsu: one-at-a-time byte/halfword load-store sequencer for a byte-wide sync memory.
// Define LSU_ALIGN_CHK_EN to reject odd-address halfwords with resp_err.
module dmem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_wr_rd_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_CAP,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_we;
  logic              r_size;
  logic [15:0]       r_rdata;
  logic              w_accept;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_addr_hi;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_addr_hi = r_addr + ADDR_W'(1);

`ifdef LSU_ALIGN_CHK_EN
  logic r_err;
  assign w_misalign = req_size && req_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_misalign ? S_RESP : S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        if (r_size) begin
          w_next = S_ISSUE1;
        end else if (r_we) begin
          w_next = S_RESP;
        end else begin
          w_next = S_CAP;
        end
      end
      S_ISSUE1: w_next = r_we ? S_RESP : S_CAP;
      S_CAP:    w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Read data lands one cycle after each read issue, so byte0 of a
  // halfword is caught in ISSUE1 and the final byte in CAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= 1'b0;
      r_rdata <= '0;
`ifdef LSU_ALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
        r_size  <= req_size;
        r_rdata <= '0;
`ifdef LSU_ALIGN_CHK_EN
        r_err   <= w_misalign;
`endif
      end
      if (r_state == S_ISSUE1 && !r_we) begin
        r_rdata[7:0] <= mem_rdata;
      end
      if (r_state == S_CAP) begin
        if (r_size) begin
          r_rdata[15:8] <= mem_rdata;
        end else begin
          r_rdata[7:0] <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_en       = 1'b0;
    mem_wr_rd_n  = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wdata_oe = 1'b0;
    unique case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_ISSUE0: begin
        mem_en       = 1'b1;
        mem_wr_rd_n  = r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_we ? r_wdata[7:0] : 8'h00;
        mem_wdata_oe = r_we;
      end
      S_ISSUE1: begin
        mem_en       = 1'b1;
        mem_wr_rd_n  = r_we;
        mem_addr     = w_addr_hi;
        mem_wdata    = r_we ? r_wdata[15:8] : 8'h00;
        mem_wdata_oe = r_we;
      end
      S_CAP: begin
        mem_en = 1'b0;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
`ifdef LSU_ALIGN_CHK_EN
        resp_err   = r_err;
`endif
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with a behavioural byte memory.
// Honours LSU_ALIGN_CHK_EN when computing expected responses.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_wr_rd_n;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wdata_oe;
  logic [7:0]  mem_rdata;

  dmem_lsu #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_wr_rd_n  (mem_wr_rd_n),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem   [256] = '{default: 8'h00};
  logic [7:0] model [256] = '{default: 8'h00};
  int         cyc = 0;
  int         acc = 0;
  int         total = 0;
  int         bad = 0;
  int         oe_bad = 0;
  int         en_cnt = 0;

  // Memory device: read data appears the cycle after a read enable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_wr_rd_n) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_wr_rd_n) ? mem[mem_addr] : 8'hC3;
  end

  always @(negedge clk) begin
    if (mem_wdata_oe && (!mem_en || !mem_wr_rd_n)) oe_bad++;
    if (mem_en) en_cnt++;
  end

  function automatic exp_t expect_of(input bit we, input bit sz,
                                     input logic [7:0] a,
                                     input logic [15:0] wd);
    exp_t x;
    logic [7:0] a1;
    a1    = a + 8'd1;
    x.e   = 1'b0;
    x.d   = 16'h0000;
    x.lat = we ? (sz ? 3 : 2) : (sz ? 4 : 3);
`ifdef LSU_ALIGN_CHK_EN
    if (sz && a[0]) begin
      x.e   = 1'b1;
      x.lat = 1;
      return x;
    end
`endif
    if (we) begin
      model[a] = wd[7:0];
      if (sz) model[a1] = wd[15:8];
    end else begin
      x.d = sz ? {model[a1], model[a]} : {8'h00, model[a]};
    end
    return x;
  endfunction

  task automatic issue(input bit we, input bit sz, input logic [7:0] a,
                       input logic [15:0] wd, input bit push);
    int n;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
    end
    if (push) sb.push_back(expect_of(we, sz, a, wd));
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic await_resp(output logic [15:0] d, output logic e,
                            output int lat);
    int n;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout resp_valid=%b required=1", resp_valid);
    end
    d   = resp_rdata;
    e   = resp_err;
    lat = cyc - acc + 1;
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, mem_en, mem_wr_rd_n,
         mem_wdata_oe} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl got=%b required=100000",
               {req_ready, resp_valid, resp_err, mem_en, mem_wr_rd_n,
                mem_wdata_oe});
    end
    total++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h required=0",
               {resp_rdata, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL post_reset rdy=%b en=%b required 1/0", req_ready, mem_en);
    end
  endtask

  task automatic test_byte_store();
    logic [15:0] d; logic e; int lat; exp_t x;
    issue(1'b1, 1'b0, 8'h10, 16'h33A5, 1'b1);
    total++;
    if ({mem_en, mem_wr_rd_n, mem_wdata_oe, mem_addr, mem_wdata}
        !== {3'b111, 8'h10, 8'hA5}) begin
      bad++;
      $display("FAIL bs_issue got=%b_%h_%h required=111_10_a5",
               {mem_en, mem_wr_rd_n, mem_wdata_oe}, mem_addr, mem_wdata);
    end
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL bs_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
  endtask

  task automatic test_half_store_load();
    logic [15:0] d; logic e; int lat; exp_t x; int oe0;
    issue(1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b1);
    total++;
    if ({mem_en, mem_wr_rd_n, mem_addr, mem_wdata} !== {2'b11, 8'h20, 8'hEF}) begin
      bad++;
      $display("FAIL hs_issue0 addr=%h wd=%h required 20/ef", mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if ({mem_en, mem_wr_rd_n, mem_wdata_oe, mem_addr, mem_wdata}
        !== {3'b111, 8'h21, 8'hBE}) begin
      bad++;
      $display("FAIL hs_issue1 addr=%h wd=%h required 21/be", mem_addr, mem_wdata);
    end
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL hs_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
    oe0 = oe_bad;
    issue(1'b0, 1'b1, 8'h20, 16'h0000, 1'b1);
    total++;
    if ({mem_en, mem_wr_rd_n, mem_wdata_oe} !== 3'b100) begin
      bad++;
      $display("FAIL hl_issue0 en/wr/oe=%b required=100",
               {mem_en, mem_wr_rd_n, mem_wdata_oe});
    end
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL hl_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
    total++;
    if (oe_bad !== oe0) begin
      bad++;
      $display("FAIL hl_oe driven_cycles=%0d required=0", oe_bad - oe0);
    end
  endtask

  task automatic test_byte_load();
    logic [15:0] d; logic e; int lat; exp_t x;
    issue(1'b0, 1'b0, 8'h21, 16'hFFFF, 1'b1);
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL bl_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
  endtask

  task automatic test_wrap();
    logic [15:0] d; logic e; int lat; exp_t x; int en0;
    issue(1'b1, 1'b0, 8'hFF, 16'h0011, 1'b1);
    await_resp(d, e, lat);
    void'(sb.pop_front());
    retire();
    issue(1'b1, 1'b0, 8'h00, 16'h0022, 1'b1);
    await_resp(d, e, lat);
    void'(sb.pop_front());
    retire();
    en0 = en_cnt;
    issue(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b1);
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL wrap_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
    total++;
`ifdef LSU_ALIGN_CHK_EN
    if (en_cnt !== en0) begin
      bad++;
      $display("FAIL wrap_en mem_en_cycles=%0d required=0", en_cnt - en0);
    end
`else
    if (en_cnt !== en0 + 2) begin
      bad++;
      $display("FAIL wrap_en mem_en_cycles=%0d required=2", en_cnt - en0);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [15:0] d; logic e; int lat; exp_t x;
    issue(1'b0, 1'b0, 8'h10, 16'h0000, 1'b1);
    await_resp(d, e, lat);
    req_we    = 1'b0;
    req_size  = 1'b0;
    req_addr  = 8'h20;
    req_wdata = 16'h0000;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== sb[0].d || req_ready !== 1'b0
          || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d v=%b d=%h rdy=%b en=%b required 1/%h/0/0",
                 i, resp_valid, resp_rdata, req_ready, mem_en, sb[0].d);
      end
      @(negedge clk);
    end
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL bp_resp got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
    total++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_after rdy=%b en=%b v=%b required 1/0/0",
               req_ready, mem_en, resp_valid);
    end
    sb.push_back(expect_of(1'b0, 1'b0, 8'h20, 16'h0000));
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h20) begin
      bad++;
      $display("FAIL bp_accept en=%b addr=%h required 1/20", mem_en, mem_addr);
    end
    await_resp(d, e, lat);
    x = sb.pop_front();
    total++;
    if (lat !== x.lat || e !== x.e || d !== x.d) begin
      bad++;
      $display("FAIL bp_next got lat=%0d err=%b d=%h required %0d/%b/%h",
               lat, e, d, x.lat, x.e, x.d);
    end
    retire();
  endtask

  task automatic test_abort_reset();
    int seen;
    issue(1'b1, 1'b1, 8'h40, 16'h1234, 1'b0);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h41) begin
      bad++;
      $display("FAIL ab_issue1 en=%b addr=%h required 1/41", mem_en, mem_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL ab_reset en=%b rdy=%b v=%b required 0/1/0",
               mem_en, req_ready, resp_valid);
    end
    rst_n = 1'b1;
    seen = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    resp_ready = 1'b0;
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL ab_noresp resp_cycles=%0d required=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic e; int lat; exp_t x;
    bit we; bit sz; logic [7:0] a; logic [15:0] wd;
    for (int i = 0; i < 16; i++) begin
      we = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      a  = 8'h80 + 8'($urandom_range(0, 14));
      wd = 16'($urandom);
      issue(we, sz, a, wd, 1'b1);
      await_resp(d, e, lat);
      x = sb.pop_front();
      total++;
      if (lat !== x.lat || e !== x.e || d !== x.d) begin
        bad++;
        $display("FAIL b2b%0d we=%b sz=%b a=%h got lat=%0d err=%b d=%h required %0d/%b/%h",
                 i, we, sz, a, lat, e, d, x.lat, x.e, x.d);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      retire();
    end
    total++;
    if (oe_bad !== 0) begin
      bad++;
      $display("FAIL bus_oe driven_while_not_writing=%0d required=0", oe_bad);
    end
  endtask

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 16'h0000;
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    test_reset();
    test_byte_store();
    test_half_store_load();
    test_byte_load();
    test_wrap();
    test_backpressure();
    test_abort_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit directly upstream of the byte-wide data memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Sequences byte or little-endian halfword accesses onto the memory's synchronous single-port interface (en, wr_rd_n, address, byte data). Returns read data and status over a valid/ready response channel.

Parameters:
ADDR_W, 8, memory address width; matches the memory's address width.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  1  0 = byte, 1 = halfword
req_addr  input  ADDR_W  byte address
req_wdata  input  16  store data; only [7:0] used for byte stores
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  16  load data; 0 for stores
resp_err  output  1  access rejected (see Optional Feature)
mem_en  output  1  memory enable
mem_wr_rd_n  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  memory byte address
mem_wdata  output  8  byte to write
mem_wdata_oe  output  1  drive enable for the shared data bus; top level tristates mem_wdata onto the memory's data pin
mem_rdata  input  8  memory read data, valid the cycle after a read enable

Behaviour:
- FSM states: IDLE, ISSUE0, ISSUE1, CAP, RESP. Memory-side outputs are decoded from the state and latched request registers only (Moore).
- Reset (rst_n=0 at a clk edge): state=IDLE; latched addr/wdata/we/size and read-data register cleared. Resulting outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_wr_rd_n=0, mem_addr=0, mem_wdata=0, mem_wdata_oe=0.
- Reset mid-operation aborts with no response. A halfword store may leave only byte0 written, which is acceptable.
- IDLE: req_ready=1. On req_valid&req_ready, latch the request and the read-data register clears. Next state is ISSUE0, or RESP with err when the optional check fails.
- ISSUE0:
  - mem_en=1, mem_addr=addr, mem_wr_rd_n=we.
  - Store: mem_wdata=wdata[7:0], oe=1.
  - Next: half → ISSUE1; byte load → CAP; byte store → RESP.
- ISSUE1:
  - mem_en=1, mem_addr=addr+1, truncated to ADDR_W (wraps 2^ADDR_W-1 → 0).
  - Store: mem_wdata=wdata[15:8], oe=1.
  - Load: capture mem_rdata into rdata[7:0].
  - Next: load → CAP, store → RESP.
- CAP: mem_en=0. Capture mem_rdata into rdata[7:0] (byte) or rdata[15:8] (half). Next state RESP.
- RESP:
  - resp_valid=1, with resp_rdata and resp_err held stable.
  - Byte loads are zero-extended.
  - Leave to IDLE only on resp_ready. Backpressure holds indefinitely with mem_en=0.
- req_ready=0 in every state except IDLE. A new request is never accepted in the same cycle a response retires; the first accept is the cycle after.
- mem_wdata_oe=0 whenever mem_en=0 or when reading. The unit never drives the bus during a read.
- Latency from accept edge to first resp_valid cycle: byte store 2, halfword store 3, byte load 3, halfword load 4.
- Throughput: at most one request in flight.

Optional Feature:
- Macro: LSU_ALIGN_CHK_EN.
- Defined: a halfword request with req_addr[0]=1 is accepted, then goes IDLE → RESP directly.
  - resp_err=1, resp_rdata=0.
  - No memory cycle is issued.
- Not defined: resp_err is tied 0. Odd-address halfwords access addr and addr+1, with wrap-around.

Test Plan:
- Reset, then byte store 0xA5 at 0x10 → one cycle mem_en=1, wr_rd_n=1, addr=0x10, wdata=0xA5, oe=1; resp_valid two cycles after accept, resp_err=0.
- Halfword store 0xBEEF at 0x20, then halfword load 0x20 → writes 0xEF@0x20 then 0xBE@0x21; load returns resp_rdata=0xBEEF four cycles after accept; oe=0 throughout the load.
- Byte load from 0x21 after the above → resp_rdata=0x00BE.
- Halfword load at 0xFF (ADDR_W=8), with 0x11 stored @0xFF and 0x22 @0x00 → resp_rdata=0x2211 without the macro. With LSU_ALIGN_CHK_EN: resp_err=1, rdata=0, mem_en never asserted.
- Hold resp_ready=0 for 5 cycles → resp_valid and data stable, req_ready=0, mem_en=0; new req_valid is ignored until the cycle after resp_ready handshake.
- Assert rst_n=0 during ISSUE1 of a halfword store → next cycle mem_en=0, req_ready=1, resp_valid=0; no response is ever produced for the aborted request.
